mdio_responder: RTL
===================

MDIO_RESPONDER -- requirements
Module: mdio_responder

Interface
REQ-001 Parameter PHY_ADDR, default 0: 5-bit PHY address this block answers to.
REQ-002 Parameter PHY_ID1, default 16'h0000: read-only value of register 2.
REQ-003 Parameter PHY_ID2, default 16'h0000: read-only value of register 3.
REQ-004 Parameter MIN_PREAMBLE, default 32: consecutive 1 bits required before a start delimiter.
REQ-005 clk  in  1  single clock; all logic on posedge clk.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 mdc  in  1  management clock from the MD master, asynchronous to clk.
REQ-008 mdio_in  in  1  management data from the line, asynchronous to clk.
REQ-009 mdio_out  out  1  data driven to the line.
REQ-010 mdio_en  out  1  output enable; 1 = block drives the line.
REQ-011 wr_strobe  out  1  one-clk pulse per accepted write frame.
REQ-012 wr_addr  out  5  register address of the last accepted write.
REQ-013 wr_data  out  16  data of the last accepted write.
REQ-014 rd_strobe  out  1  one-clk pulse when an addressed read frame completes.

Function
REQ-015 mdc and mdio_in SHALL each pass through a 2-flop synchronizer; a bit event is sync'd mdc 0->1, with sync'd mdio_in sampled in the same clk.
REQ-016 The register file SHALL be 32 x 16 bits; registers 2 and 3 SHALL read PHY_ID1/PHY_ID2, and writes to them SHALL be discarded without wr_strobe.
REQ-017 States: IDLE, START, OP, PHYAD, REGAD, TA, WDATA, RDATA; only IDLE is left by preamble; every other state advances on bit events only.
REQ-018 IDLE: 6-bit saturating count of consecutive 1 bits; a 0 with count < MIN_PREAMBLE clears the count; a 0 with count >= MIN_PREAMBLE enters START.
REQ-019 START: a 1 enters OP; a 0 returns to IDLE with the count cleared.
REQ-020 OP: 2 bits, MSB first; 10 = read, 01 = write; 00/11 return to IDLE with the count cleared.
REQ-021 PHYAD/REGAD: 5 bits each, MSB first; addressed = (PHYAD == PHY_ADDR).
REQ-022 TA, write: 2 bits consumed unchecked, then WDATA.
REQ-023 WDATA: 16 bits, MSB first; on the 16th bit event, if addressed and register not 2/3, the block SHALL write the register, load wr_addr/wr_data and pulse wr_strobe in the same clk; then IDLE.
REQ-024 TA, read, addressed: on the bit event of TA bit 1, mdio_en=1 and mdio_out=0; on the next bit event, mdio_out=D15 and RDATA is entered.
REQ-025 RDATA: each bit event shifts out the next bit, D14..D0. The bit event after D0 SHALL set mdio_en=0, pulse rd_strobe and return to IDLE.
REQ-026 Read data SHALL be captured at the end of REGAD; a concurrent write cannot occur, since frames are serial.
REQ-027 Not addressed: the frame SHALL be tracked to its end with mdio_en held 0 and no strobes.
REQ-028 Latency from the pin mdc rising edge to a mdio_out/mdio_en change SHALL be <= 4 clk (2 sync + edge detect + registered output); outputs SHALL be registered.
REQ-029 Leaving RDATA or TA by any path SHALL deassert mdio_en in the same clk.
REQ-030 Preamble count in IDLE SHALL restart from 0 after each frame, so back-to-back frames each need MIN_PREAMBLE ones.

Reset
REQ-031 rst=1 SHALL force, on the next posedge: state IDLE, preamble count 0, mdio_en=0, mdio_out=0, wr_strobe=0, rd_strobe=0, wr_addr=0, wr_data=0, all writable registers 0, synchronizer flops 0.
REQ-032 rst asserted mid-frame SHALL abort the frame with no strobe; mdio_en SHALL be 0 the clk after rst is sampled.

Verification
REQ-033 PHY_ADDR=5: 32 ones, then 01 01 00101 00000 10 + 0x1234 -> one wr_strobe, wr_addr=0, wr_data=0x1234; a following read of reg 0 -> TA2=0, D15..D0=0x1234, then rd_strobe and mdio_en=0.
REQ-034 PHY_ID1=0x0022: read of reg 2 -> 0x0022 on the line. A prior write of 0xFFFF to reg 2 -> no wr_strobe; the read still returns 0x0022.
REQ-035 Write then read with PHYAD=6 (PHY_ADDR=5) -> mdio_en stays 0 for both frames; no wr_strobe or rd_strobe.
REQ-036 Only 31 preamble ones before 01, then a full write frame -> ignored, no wr_strobe. After a full 32-one preamble, opcode 11 -> ignored; the next valid frame is accepted.
REQ-037 rst pulsed during RDATA bit D8 -> mdio_en=0 the next clk, no rd_strobe, reg 0 reads back 0 after reset.
REQ-038 mdc period 200 clk, jitter of mdc edges vs clk -> every mdio_out change within 4 clk of the mdc rising edge.

Source files
------------

// File: rtl/mdio_responder_if.sv
// MDIO responder bus: line signals from the MD master plus the write/read
// notification outputs towards the local register consumer.
interface mdio_responder_if;
  logic        mdc;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_en;
  logic        wr_strobe;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_strobe;

  modport slave (
    input  mdc, mdio_in,
    output mdio_out, mdio_en, wr_strobe, wr_addr, wr_data, rd_strobe
  );

  modport master (
    output mdc, mdio_in,
    input  mdio_out, mdio_en, wr_strobe, wr_addr, wr_data, rd_strobe
  );
endinterface

// File: rtl/mdio_responder.sv
// Clause-22 style MDIO responder: oversamples mdc/mdio on clk, decodes
// preamble/start/op/phyad/regad/ta/data frames and serves a 32x16 register
// file whose registers 2 and 3 are the read-only PHY identifiers.
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd0,
  parameter logic [15:0] PHY_ID1      = 16'h0000,
  parameter logic [15:0] PHY_ID2      = 16'h0000,
  parameter int          MIN_PREAMBLE = 32
) (
  input  logic           clk,
  input  logic           rst,
  mdio_responder_if.slave mif
);

  localparam int unsigned MIN_PRE = MIN_PREAMBLE;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA
  } state_t;

  // control / output flops
  state_t      state_q, state_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        mdc_s1_q, mdc_s1_d;
  logic        mdc_s2_q, mdc_s2_d;
  logic        mdc_s3_q, mdc_s3_d;
  logic        mdio_s1_q, mdio_s1_d;
  logic        mdio_s2_q, mdio_s2_d;
  logic        mdio_out_q, mdio_out_d;
  logic        mdio_en_q, mdio_en_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic        rd_strobe_q, rd_strobe_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;

  // frame datapath flops
  logic        op_hi_q, op_hi_d;
  logic        is_rd_q, is_rd_d;
  logic        addressed_q, addressed_d;
  logic [4:0]  phyad_q, phyad_d;
  logic [4:0]  regad_q, regad_d;
  logic [15:0] shift_q, shift_d;

  logic [15:0] regs_q [32];

  logic        bit_evt;
  logic        bit_s;
  logic [4:0]  ra;
  logic [15:0] rd_word;
  logic        wr_fire;

  assign bit_evt = mdc_s2_q & ~mdc_s3_q;
  assign bit_s   = mdio_s2_q;

  // Next-state decode: synchronizers, frame FSM and registered outputs.
  always_comb begin
    mdc_s1_d    = mif.mdc;
    mdc_s2_d    = mdc_s1_q;
    mdc_s3_d    = mdc_s2_q;
    mdio_s1_d   = mif.mdio_in;
    mdio_s2_d   = mdio_s1_q;
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    mdio_out_d  = mdio_out_q;
    mdio_en_d   = mdio_en_q;
    wr_strobe_d = 1'b0;
    rd_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    op_hi_d     = op_hi_q;
    is_rd_d     = is_rd_q;
    addressed_d = addressed_q;
    phyad_d     = phyad_q;
    regad_d     = regad_q;
    shift_d     = shift_q;
    wr_fire     = 1'b0;
    ra          = {regad_q[3:0], bit_s};
    if (ra == 5'd2)      rd_word = PHY_ID1;
    else if (ra == 5'd3) rd_word = PHY_ID2;
    else                 rd_word = regs_q[ra];

    if (bit_evt) begin
      case (state_q)
        S_IDLE: begin
          if (bit_s) begin
            if (pre_cnt_q != 6'h3f) pre_cnt_d = pre_cnt_q + 6'd1;
          end else if ({26'd0, pre_cnt_q} >= MIN_PRE) begin
            state_d   = S_START;
            pre_cnt_d = 6'd0;
          end else begin
            pre_cnt_d = 6'd0;
          end
        end
        S_START: begin
          bit_cnt_d = 4'd0;
          state_d   = bit_s ? S_OP : S_IDLE;
        end
        S_OP: begin
          if (bit_cnt_q == 4'd0) begin
            op_hi_d   = bit_s;
            bit_cnt_d = 4'd1;
          end else begin
            bit_cnt_d = 4'd0;
            if ({op_hi_q, bit_s} == 2'b10) begin
              is_rd_d = 1'b1;
              state_d = S_PHYAD;
            end else if ({op_hi_q, bit_s} == 2'b01) begin
              is_rd_d = 1'b0;
              state_d = S_PHYAD;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_PHYAD: begin
          phyad_d = {phyad_q[3:0], bit_s};
          if (bit_cnt_q == 4'd4) begin
            bit_cnt_d = 4'd0;
            state_d   = S_REGAD;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        S_REGAD: begin
          regad_d = ra;
          if (bit_cnt_q == 4'd4) begin
            // Read data is snapshotted here so the shift register owns it.
            addressed_d = (phyad_q == PHY_ADDR);
            shift_d     = rd_word;
            bit_cnt_d   = 4'd0;
            state_d     = S_TA;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        S_TA: begin
          if (bit_cnt_q == 4'd0) begin
            bit_cnt_d = 4'd1;
            if (is_rd_q && addressed_q) begin
              mdio_en_d  = 1'b1;
              mdio_out_d = 1'b0;
            end
          end else begin
            bit_cnt_d = 4'd0;
            if (is_rd_q) begin
              state_d = S_RDATA;
              if (addressed_q) begin
                mdio_out_d = shift_q[15];
                shift_d    = {shift_q[14:0], 1'b0};
              end
            end else begin
              state_d = S_WDATA;
            end
          end
        end
        S_WDATA: begin
          shift_d = {shift_q[14:0], bit_s};
          if (bit_cnt_q == 4'd15) begin
            bit_cnt_d = 4'd0;
            state_d   = S_IDLE;
            if (addressed_q && (regad_q[4:1] != 4'b0001)) begin
              wr_fire     = 1'b1;
              wr_strobe_d = 1'b1;
              wr_addr_d   = regad_q;
              wr_data_d   = {shift_q[14:0], bit_s};
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        S_RDATA: begin
          if (bit_cnt_q == 4'd15) begin
            bit_cnt_d  = 4'd0;
            state_d    = S_IDLE;
            mdio_en_d  = 1'b0;
            mdio_out_d = 1'b0;
            rd_strobe_d = addressed_q;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (addressed_q) begin
              mdio_out_d = shift_q[15];
              shift_d    = {shift_q[14:0], 1'b0};
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control state, synchronizers and registered outputs with sync reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pre_cnt_q   <= 6'd0;
      bit_cnt_q   <= 4'd0;
      mdc_s1_q    <= 1'b0;
      mdc_s2_q    <= 1'b0;
      mdc_s3_q    <= 1'b0;
      mdio_s1_q   <= 1'b0;
      mdio_s2_q   <= 1'b0;
      mdio_out_q  <= 1'b0;
      mdio_en_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      wr_addr_q   <= 5'd0;
      wr_data_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      mdc_s1_q    <= mdc_s1_d;
      mdc_s2_q    <= mdc_s2_d;
      mdc_s3_q    <= mdc_s3_d;
      mdio_s1_q   <= mdio_s1_d;
      mdio_s2_q   <= mdio_s2_d;
      mdio_out_q  <= mdio_out_d;
      mdio_en_q   <= mdio_en_d;
      wr_strobe_q <= wr_strobe_d;
      rd_strobe_q <= rd_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Frame field registers; only meaningful once the FSM has filled them.
  always_ff @(posedge clk) begin
    op_hi_q     <= op_hi_d;
    is_rd_q     <= is_rd_d;
    addressed_q <= addressed_d;
    phyad_q     <= phyad_d;
    regad_q     <= regad_d;
    shift_q     <= shift_d;
  end

  // Register file: cleared by reset, written at the end of an accepted write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 16'd0;
    end else if (wr_fire) begin
      regs_q[regad_q] <= wr_data_d;
    end
  end

  assign mif.mdio_out  = mdio_out_q;
  assign mif.mdio_en   = mdio_en_q;
  assign mif.wr_strobe = wr_strobe_q;
  assign mif.rd_strobe = rd_strobe_q;
  assign mif.wr_addr   = wr_addr_q;
  assign mif.wr_data   = wr_data_q;

endmodule
